// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-and-add multiplier.
//   mult_state_t : controller states (IDLE, RUN, DONE)
//   cnt_width()  : width of the step counter for a given operand width
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  // The step counter needs $clog2(WIDTH) bits, but never less than one.
  function automatic int unsigned cnt_width(input int unsigned w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/seq_shift_add_mult_rca.sv
// WIDTH-bit combinational ripple-carry adder built from 1-bit full-adder cells.
//   x, y : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out of the MSB cell
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module rca_add #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/seq_shift_add_mult.sv
// Iterative unsigned shift-and-add multiplier, one add/shift step per clock.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b                 : multiplicand, multiplier (WIDTH bits, unsigned)
//   out_valid / out_ready: result handshake (valid only in DONE)
//   product              : {hi, lo}, 2*WIDTH bits
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | WIDTH add/shift steps, counted by cnt
// DONE  | product held, out_valid high until out_ready
module seq_shift_add_mult
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;

  assign addend = lo_q[0] ? mcand_q : '0;

  rca_add #(.WIDTH(WIDTH)) u_add (
    .x    (hi_q),
    .y    (addend),
    .cin  (1'b0),
    .s    (sum),
    .cout (carry)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // {carry, sum, lo} shifted right by one: the carry lands in the hi MSB
        // and the sum LSB drops into the lo MSB.
        hi_d  = {carry, sum[WIDTH-1:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = {hi_q, lo_q};

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  logic [2:0]  out_ready_v;
  logic [15:0] a_drv, b_drv;

  logic        ir8, ov8, ir4, ov4, ir16, ov16;
  logic [15:0] p8;
  logic [7:0]  p4;
  logic [31:0] p16;

  int          sel;
  logic        ir, ov;
  logic [31:0] prod;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_add_mult #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(ir8),
    .a(a_drv[7:0]), .b(b_drv[7:0]), .out_valid(ov8), .out_ready(out_ready_v[0]),
    .product(p8));

  seq_shift_add_mult #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(ir4),
    .a(a_drv[3:0]), .b(b_drv[3:0]), .out_valid(ov4), .out_ready(out_ready_v[1]),
    .product(p4));

  seq_shift_add_mult #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(ir16),
    .a(a_drv), .b(b_drv), .out_valid(ov16), .out_ready(out_ready_v[2]),
    .product(p16));

  always_comb begin
    ir = ir8; ov = ov8; prod = {16'b0, p8};
    case (sel)
      1: begin ir = ir4;  ov = ov4;  prod = {24'b0, p4}; end
      2: begin ir = ir16; ov = ov16; prod = p16;         end
      default: ;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One multiply on instance s: accept, wait for result, optional stall, handoff.
  task automatic do_op(input int s, input logic [15:0] av, input logic [15:0] bv, input int stall);
    int n;
    int w;
    logic [31:0] exp;
    w   = (s == 0) ? 8 : (s == 1) ? 4 : 16;
    exp = 32'(av) * 32'(bv);
    sel = s;
    @(negedge clk);
    chk("in_ready_idle", 32'(ir), 1);
    a_drv = av; b_drv = bv;
    in_valid_v = '0; in_valid_v[s] = 1'b1; out_ready_v = '0;
    @(negedge clk);
    in_valid_v = '0;
    a_drv = 16'($urandom); b_drv = 16'($urandom);
    n = 0;
    while (!ov && n < 100) begin
      @(negedge clk);
      n++;
      if (n == 2) begin a_drv = 16'($urandom); b_drv = 16'($urandom); end
    end
    chk("latency", 32'(n), 32'(w));
    chk("product", prod, exp);
    chk("in_ready_done", 32'(ir), 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(ov), 1);
      chk("hold_product", prod, exp);
      chk("hold_in_ready", 32'(ir), 0);
    end
    out_ready_v[s] = 1'b1;
    @(negedge clk);
    out_ready_v = '0;
    chk("handoff_valid", 32'(ov), 0);
    chk("handoff_ready", 32'(ir), 1);
  endtask

  initial begin
    int k, e1, e2;
    logic prev_ir;
    logic [31:0] results[$];

    sel = 0;
    rst_n = 1'b0;
    in_valid_v = '0; out_ready_v = '0;
    a_drv = '0; b_drv = '0;

    @(negedge clk);
    chk("rst_in_ready", 32'(ir), 1);
    chk("rst_out_valid", 32'(ov), 0);
    chk("rst_product", prod, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(ir), 1);
    chk("post_rst_out_valid", 32'(ov), 0);
    chk("post_rst_product", prod, 0);

    do_op(0, 13, 11, 0);
    do_op(0, 255, 255, 0);
    do_op(0, 0, 200, 0);
    do_op(0, 200, 0, 0);
    do_op(0, 7, 9, 5);

    // Back-to-back with in_valid held high; operands scrambled mid-run.
    sel = 0;
    @(negedge clk);
    a_drv = 3; b_drv = 5;
    in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b1;
    prev_ir = ir;
    k = 0; e1 = -1; e2 = -1;
    results.delete();
    while (results.size() < 2 && k < 60) begin
      @(negedge clk);
      k++;
      if (prev_ir && in_valid_v[0]) begin
        if (e1 < 0) e1 = k;
        else begin e2 = k; in_valid_v[0] = 1'b0; end
      end
      if (e1 >= 0 && e2 < 0 && k == e1 + 2) begin a_drv = 16'($urandom); b_drv = 16'($urandom); end
      if (e1 >= 0 && e2 < 0 && k == e1 + 6) begin a_drv = 6; b_drv = 7; end
      if (ov) results.push_back(prod);
      prev_ir = ir;
    end
    in_valid_v = '0; out_ready_v = '0;
    chk("b2b_count", 32'(results.size()), 2);
    chk("b2b_spacing", 32'(e2 - e1), 10);
    if (results.size() == 2) begin
      chk("b2b_first", results[0], 15);
      chk("b2b_second", results[1], 42);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a run.
    sel = 0;
    a_drv = 100; b_drv = 100; in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v = '0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ov), 0);
    chk("midrst_in_ready", 32'(ir), 1);
    chk("midrst_product", prod, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(0, 12, 12, 0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        do_op(1, 16'(x), 16'(y), int'($urandom_range(0, 2)));

    for (int i = 0; i < 1000; i++)
      do_op(2, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
